pupil_locator: RTL

Streaming dark-region locator for the Stonyman imager path. It sits between the per-camera ADC/FIFO output and the APB register bank, one instance per camera. The block consumes one frame of raster-order pixels and reports the pupil location as a horizontal/vertical coordinate pair. It generalises the fixed 112×112 pupil detect with configurable resolution, pixel width, threshold, minimum-area rejection, a centroid or bounding-box mode, and a valid/ready input handshake.

---
 rtl/pupil_locator_if.sv | 17 +
 rtl/pupil_locator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pupil_locator_if.sv
// Pixel stream bundle between the camera ADC/FIFO and pupil_locator.
//   pix_valid : source has a pixel
//   pix_ready : sink accepts it (transfer on pix_valid & pix_ready)
//   pix_sof   : marks pixel (0,0) of a frame
//   pix_data  : pixel sample
// master = pixel source, slave = pupil_locator.
interface pupil_locator_if #(
    parameter int PIXEL_W = 8
) ();
    logic               pix_valid;
    logic               pix_ready;
    logic               pix_sof;
    logic [PIXEL_W-1:0] pix_data;

    modport master (output pix_valid, pix_sof, pix_data, input pix_ready);
    modport slave  (input pix_valid, pix_sof, pix_data, output pix_ready);
endinterface

// File: rtl/pupil_locator.sv
// Streaming dark-region (pupil) locator, one instance per camera.
// Consumes one raster-order frame and reports either the centroid or the
// bounding-box centre of all pixels below a threshold.
//   clk, reset        : clock, synchronous active-low reset
//   pix               : pixel stream (valid/ready/sof/data), slave side
//   threshold, mode,
//   min_count         : frame configuration, captured on the SOF transfer
//   loc_h, loc_v      : result column / row (held until the next result)
//   loc_found         : last result had enough dark pixels
//   loc_valid         : one-cycle result strobe
//   busy              : not idle
//   frame_err         : one-cycle pulse when an SOF arrives mid-frame
module pupil_locator #(
    parameter  int RES_H   = 112,
    parameter  int RES_V   = 112,
    parameter  int PIXEL_W = 8,
    parameter  int COORD_W = 8,
    localparam int CNT_W   = $clog2(RES_H*RES_V+1),
    localparam int SUM_W   = CNT_W + COORD_W
) (
    input  logic               clk,
    input  logic               reset,
    pupil_locator_if.slave     pix,
    input  logic [PIXEL_W-1:0] threshold,
    input  logic               mode,
    input  logic [CNT_W-1:0]   min_count,
    output logic [COORD_W-1:0] loc_h,
    output logic [COORD_W-1:0] loc_v,
    output logic               loc_found,
    output logic               loc_valid,
    output logic               busy,
    output logic               frame_err
);
    localparam int BIT_W = $clog2(SUM_W);
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(RES_H-1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(RES_V-1);
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(SUM_W-1);

    typedef enum logic [2:0] {IDLE, ACCUM, DIV_H, DIV_V, DONE} state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
    logic [CNT_W-1:0]   count_q, count_d, min_cnt_q, min_cnt_d;
    logic [SUM_W-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [COORD_W-1:0] min_c_q, min_c_d, max_c_q, max_c_d;
    logic [COORD_W-1:0] min_r_q, min_r_d, max_r_q, max_r_d;
    logic [PIXEL_W-1:0] thr_q, thr_d;
    logic               mode_q, mode_d;
    logic [SUM_W-1:0]   dvd_q, dvd_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [COORD_W-1:0] quo_h_q, quo_h_d;
    logic [COORD_W-1:0] loc_h_q, loc_h_d, loc_v_q, loc_v_d;
    logic               found_q, found_d, valid_q, valid_d, ferr_q, ferr_d;

    logic               xfer, start, take, dark, last_pix;
    logic [COORD_W-1:0] pcol, prow;
    logic [CNT_W:0]     trial;
    logic               trial_ge;
    logic [SUM_W-1:0]   quot_nxt;
    logic [CNT_W-1:0]   rem_nxt;
    logic [COORD_W:0]   bb_h, bb_v;

    always_comb begin
        // Handshake decode; ready is only high in IDLE/ACCUM
        xfer  = pix.pix_valid & pix.pix_ready;
        start = xfer & pix.pix_sof;
        take  = start | (xfer & (state_q == ACCUM));
        pcol  = start ? '0 : col_q;
        prow  = start ? '0 : row_q;
        last_pix = (pcol == LAST_COL) && (prow == LAST_ROW);

        // Restoring divide step: dvd_q shifts the dividend out of its top
        // and collects quotient bits at its bottom.
        trial    = {rem_q, dvd_q[SUM_W-1]};
        trial_ge = trial >= {1'b0, count_q};
        quot_nxt = {dvd_q[SUM_W-2:0], trial_ge};
        rem_nxt  = trial_ge ? CNT_W'(trial - {1'b0, count_q}) : trial[CNT_W-1:0];

        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        count_d   = count_q;
        min_cnt_d = min_cnt_q;
        sum_x_d   = sum_x_q;
        sum_y_d   = sum_y_q;
        min_c_d   = min_c_q;
        max_c_d   = max_c_q;
        min_r_d   = min_r_q;
        max_r_d   = max_r_q;
        thr_d     = thr_q;
        mode_d    = mode_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        bit_d     = bit_q;
        quo_h_d   = quo_h_q;
        loc_h_d   = loc_h_q;
        loc_v_d   = loc_v_q;
        found_d   = found_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        dark      = 1'b0;
        bb_h      = '0;
        bb_v      = '0;

        case (state_q)
            IDLE, ACCUM: begin
                if (take) begin
                    if (start) begin
                        thr_d     = threshold;
                        mode_d    = mode;
                        min_cnt_d = min_count;
                        count_d   = '0;
                        sum_x_d   = '0;
                        sum_y_d   = '0;
                        min_c_d   = '1;
                        max_c_d   = '0;
                        min_r_d   = '1;
                        max_r_d   = '0;
                        ferr_d    = (state_q == ACCUM);
                    end
                    dark = pix.pix_data < thr_d;
                    if (dark) begin
                        count_d = count_d + CNT_W'(1);
                        sum_x_d = sum_x_d + SUM_W'(pcol);
                        sum_y_d = sum_y_d + SUM_W'(prow);
                        if (pcol < min_c_d) min_c_d = pcol;
                        if (pcol > max_c_d) max_c_d = pcol;
                        if (prow < min_r_d) min_r_d = prow;
                        if (prow > max_r_d) max_r_d = prow;
                    end
                    if (pcol == LAST_COL) begin
                        col_d = '0;
                        row_d = (prow == LAST_ROW) ? '0 : prow + COORD_W'(1);
                    end else begin
                        col_d = pcol + COORD_W'(1);
                        row_d = prow;
                    end
                    state_d = ACCUM;
                    // Decide on the totals including this final pixel
                    if (last_pix) begin
                        bb_h = {1'b0, min_c_d} + {1'b0, max_c_d};
                        bb_v = {1'b0, min_r_d} + {1'b0, max_r_d};
                        if (count_d == '0 || count_d < min_cnt_d) begin
                            state_d = DONE;
                            loc_h_d = '0;
                            loc_v_d = '0;
                            found_d = 1'b0;
                            valid_d = 1'b1;
                        end else if (mode_d) begin
                            state_d = DONE;
                            loc_h_d = COORD_W'(bb_h >> 1);
                            loc_v_d = COORD_W'(bb_v >> 1);
                            found_d = 1'b1;
                            valid_d = 1'b1;
                        end else begin
                            state_d = DIV_H;
                            dvd_d   = sum_x_d;
                            rem_d   = '0;
                            bit_d   = '0;
                        end
                    end
                end
            end
            DIV_H: begin
                dvd_d = quot_nxt;
                rem_d = rem_nxt;
                bit_d = bit_q + BIT_W'(1);
                if (bit_q == LAST_BIT) begin
                    quo_h_d = quot_nxt[COORD_W-1:0];
                    dvd_d   = sum_y_q;
                    rem_d   = '0;
                    bit_d   = '0;
                    state_d = DIV_V;
                end
            end
            DIV_V: begin
                dvd_d = quot_nxt;
                rem_d = rem_nxt;
                bit_d = bit_q + BIT_W'(1);
                if (bit_q == LAST_BIT) begin
                    loc_h_d = quo_h_q;
                    loc_v_d = quot_nxt[COORD_W-1:0];
                    found_d = 1'b1;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            count_q   <= '0;
            min_cnt_q <= '0;
            sum_x_q   <= '0;
            sum_y_q   <= '0;
            min_c_q   <= '0;
            max_c_q   <= '0;
            min_r_q   <= '0;
            max_r_q   <= '0;
            thr_q     <= '0;
            mode_q    <= 1'b0;
            dvd_q     <= '0;
            rem_q     <= '0;
            bit_q     <= '0;
            quo_h_q   <= '0;
            loc_h_q   <= '0;
            loc_v_q   <= '0;
            found_q   <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            count_q   <= count_d;
            min_cnt_q <= min_cnt_d;
            sum_x_q   <= sum_x_d;
            sum_y_q   <= sum_y_d;
            min_c_q   <= min_c_d;
            max_c_q   <= max_c_d;
            min_r_q   <= min_r_d;
            max_r_q   <= max_r_d;
            thr_q     <= thr_d;
            mode_q    <= mode_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            bit_q     <= bit_d;
            quo_h_q   <= quo_h_d;
            loc_h_q   <= loc_h_d;
            loc_v_q   <= loc_v_d;
            found_q   <= found_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign pix.pix_ready = (state_q == IDLE) || (state_q == ACCUM);
    assign busy          = (state_q != IDLE);
    assign loc_h         = loc_h_q;
    assign loc_v         = loc_v_q;
    assign loc_found     = found_q;
    assign loc_valid     = valid_q;
    assign frame_err     = ferr_q;
endmodule
